// File: rtl/inst_encoder_loader.sv
// Encodes symbolic RV32I instruction records into machine words and streams them
// into instruction memory, one registered write per accepted record.
module inst_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_index,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {F_NOP, F_R, F_I, F_SH, F_S, F_B, F_J, F_U} fmt_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   MAX_CNT  = MAX_WORDS[ADDR_W:0];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_index_q, err_index_d;

  fmt_t        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] enc_word;
  logic        imm_ok;
  logic        fits12, fits13, fits21;
  logic [ADDR_W:0] count_inc;

  always_comb begin
    fmt    = F_NOP;
    opcode = 7'h13;
    funct3 = 3'd0;
    funct7 = 7'h00;
    case (in_kind)
      5'd1:  begin fmt = F_I;  opcode = 7'h03; funct3 = 3'd2; end
      5'd2:  begin fmt = F_S;  opcode = 7'h23; funct3 = 3'd2; end
      5'd3:  begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd0; end
      5'd4:  begin fmt = F_I;  opcode = 7'h13; funct3 = 3'd0; end
      5'd5:  begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd0; funct7 = 7'h20; end
      5'd6:  begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd7; end
      5'd7:  begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd6; end
      5'd8:  begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd4; end
      5'd9:  begin fmt = F_I;  opcode = 7'h13; funct3 = 3'd7; end
      5'd10: begin fmt = F_I;  opcode = 7'h13; funct3 = 3'd6; end
      5'd11: begin fmt = F_I;  opcode = 7'h13; funct3 = 3'd4; end
      5'd12: begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd1; end
      5'd13: begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd5; end
      5'd14: begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd5; funct7 = 7'h20; end
      5'd15: begin fmt = F_SH; opcode = 7'h13; funct3 = 3'd1; end
      5'd16: begin fmt = F_SH; opcode = 7'h13; funct3 = 3'd5; end
      5'd17: begin fmt = F_SH; opcode = 7'h13; funct3 = 3'd5; funct7 = 7'h20; end
      5'd18: begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd2; end
      5'd19: begin fmt = F_R;  opcode = 7'h33; funct3 = 3'd3; end
      5'd20: begin fmt = F_I;  opcode = 7'h13; funct3 = 3'd2; end
      5'd21: begin fmt = F_I;  opcode = 7'h13; funct3 = 3'd3; end
      5'd22: begin fmt = F_B;  opcode = 7'h63; funct3 = 3'd0; end
      5'd23: begin fmt = F_B;  opcode = 7'h63; funct3 = 3'd1; end
      5'd24: begin fmt = F_B;  opcode = 7'h63; funct3 = 3'd4; end
      5'd25: begin fmt = F_B;  opcode = 7'h63; funct3 = 3'd5; end
      5'd26: begin fmt = F_B;  opcode = 7'h63; funct3 = 3'd6; end
      5'd27: begin fmt = F_B;  opcode = 7'h63; funct3 = 3'd7; end
      5'd28: begin fmt = F_J;  opcode = 7'h6F; end
      5'd29: begin fmt = F_I;  opcode = 7'h67; funct3 = 3'd0; end
      5'd30: begin fmt = F_U;  opcode = 7'h37; end
      5'd31: begin fmt = F_U;  opcode = 7'h17; end
      default: ;
    endcase
  end

  // A signed value fits in N bits when every bit above N-1 equals the sign bit.
  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    enc_word = 32'h0000_0013;
    imm_ok   = 1'b1;
    case (fmt)
      F_R:  enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, opcode};
      F_I:  begin
        enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, opcode};
        imm_ok   = fits12;
      end
      F_SH: begin
        enc_word = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, opcode};
        imm_ok   = ~(|in_imm[31:5]);
      end
      F_S:  begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], opcode};
        imm_ok   = fits12;
      end
      F_B:  begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                    in_imm[4:1], in_imm[11], opcode};
        imm_ok   = fits13 & ~in_imm[0];
      end
      F_J:  begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opcode};
        imm_ok   = fits21 & ~in_imm[0];
      end
      F_U:  begin
        enc_word = {in_imm[31:12], in_rd, opcode};
        imm_ok   = ~(|in_imm[11:0]);
      end
      default: ;
    endcase
  end

  assign count_inc = count_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    addr_ptr_d  = addr_ptr_q;
    count_d     = count_q;
    wen_d       = 1'b0;
    done_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    err_index_d = err_index_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (!imm_ok) begin
            state_d     = S_ERR;
            err_d       = 1'b1;
            err_index_d = count_q[ADDR_W-1:0];
          end else begin
            wen_d      = 1'b1;
            addr_d     = addr_ptr_q;
            wdata_d    = enc_word;
            addr_ptr_d = addr_ptr_q + ADDR_ONE;
            count_d    = count_inc;
            // done rides with the registered write so it pulses with the final word
            if (in_last || (count_inc == MAX_CNT)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d     = S_LOAD;
          addr_ptr_d  = base_addr;
          count_d     = '0;
          err_d       = 1'b0;
          err_index_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_ptr_q  <= '0;
      count_q     <= '0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_ptr_q  <= addr_ptr_d;
      count_q     <= count_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_index_q <= err_index_d;
    end
  end

  assign in_ready      = (state_q == S_LOAD);
  assign busy          = (state_q == S_LOAD);
  assign imem_wen      = wen_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_index     = err_index_q;
  assign words_written = count_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader: a table-driven RV32I reference model
// predicts each write; a negedge monitor pops and compares what the DUT writes.
module tb_inst_encoder_loader;

  localparam int AW   = 10;
  localparam int MAXW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_kind = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          imem_wen;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, done, err;
  logic [AW-1:0] err_index;
  logic [AW:0]   words_written;

  inst_encoder_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_wen(imem_wen), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_index(err_index),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          last;
    int            cyc;
  } exp_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  exp_t sb[$];
  wr_t  wr_log[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Format class per kind: 0 NOP, 1 R, 2 I, 3 S, 4 shift-imm, 5 B, 6 J, 7 U
  int cls_tab [32] = '{0,2,3,1,2,1,1,1,1,2,2,2,1,1,1,4,4,4,1,1,2,2,5,5,5,5,5,5,6,2,7,7};
  int opc_tab [32] = '{'h13,'h03,'h23,'h33,'h13,'h33,'h33,'h33,'h33,'h13,'h13,'h13,
                       'h33,'h33,'h33,'h13,'h13,'h13,'h33,'h33,'h13,'h13,'h63,'h63,
                       'h63,'h63,'h63,'h63,'h6F,'h67,'h37,'h17};
  int f3_tab  [32] = '{0,2,2,0,0,0,7,6,4,7,6,4,1,5,5,1,5,5,2,3,2,3,0,1,4,5,6,7,0,0,0,0};

  int m_addr, m_count, m_err_index;
  bit m_active, m_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void ref_encode(input int kind, input int rd, input int rs1,
                                     input int rs2, input int imm,
                                     output logic [31:0] w, output bit ok);
    int op, f3, f7;
    op = opc_tab[kind];
    f3 = f3_tab[kind];
    f7 = (kind == 5 || kind == 14 || kind == 17) ? 'h20 : 0;
    ok = 1;
    w  = 32'h13;
    case (cls_tab[kind])
      1: w = 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
      2: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = 32'(((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
      end
      3: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = 32'((((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                 | ((imm & 31) << 7) | op);
      end
      4: begin
        ok = (imm >= 0) && (imm <= 31);
        w  = 32'((f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
      end
      5: begin
        ok = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
        w  = 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
                 | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 'hF) << 8)
                 | (((imm >> 11) & 1) << 7) | op);
      end
      6: begin
        ok = (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
        w  = 32'((((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21)
                 | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | op);
      end
      7: begin
        ok = ((imm & 'hFFF) == 0);
        w  = 32'((imm & 'hFFFFF000) | (rd << 7) | op);
      end
      default: ;
    endcase
  endfunction

  function automatic int gen_imm(input int cls);
    bit good;
    good = ($urandom_range(0, 9) < 8);
    case (cls)
      2, 3: return good ? int'($urandom_range(0, 4095)) - 2048
                        : (($urandom_range(0, 1) == 1) ? 2048 + int'($urandom_range(0, 9999))
                                                       : -2049 - int'($urandom_range(0, 9999)));
      4:    return good ? int'($urandom_range(0, 31)) : 32 + int'($urandom_range(0, 500));
      5:    return good ? (int'($urandom_range(0, 4095)) - 2048) * 2
                        : int'($urandom_range(0, 2046)) * 2 + 1;
      6:    return good ? (int'($urandom_range(0, 1048575)) - 524288) * 2
                        : 1048576 + int'($urandom_range(0, 99999)) * 2;
      7:    return good ? int'($urandom & 32'hFFFF_F000)
                        : int'(($urandom & 32'hFFFF_F000) | $urandom_range(1, 4095));
      default: return int'($urandom);
    endcase
  endfunction

  // Monitor: every write must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (imem_wen) begin
      wr_log.push_back('{addr: imem_addr, data: imem_wdata});
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", imem_wen, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("write_addr", imem_addr, e.addr);
        checkOutput("write_data", imem_wdata, e.data);
        checkOutput("write_done", done, e.last);
        checkOutput("write_cycle", cyc, e.cyc);
      end
    end else begin
      if (done) checkOutput("done_without_write", done, 0);
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checkOutput("missed_write", imem_wen, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic start_session(input logic [AW-1:0] base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1;
    start    = 1'b0;
    m_addr   = int'(base);
    m_count  = 0;
    m_active = 1;
    m_err    = 0;
    wr_log.delete();
    checkOutput("start_busy", busy, 1);
    checkOutput("start_ready", in_ready, 1);
    checkOutput("start_err", err, 0);
    checkOutput("start_count", words_written, 0);
  endtask

  task automatic applyStimulus(input int kind, input int rd, input int rs1, input int rs2,
                               input int imm, input bit last);
    logic [31:0] w;
    bit ok;
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_kind  = 5'(kind);
    in_rd    = 5'(rd);
    in_rs1   = 5'(rs1);
    in_rs2   = 5'(rs2);
    in_imm   = 32'(imm);
    in_last  = last;
    budget   = 20;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      m_active = 0;
      return;
    end
    ref_encode(kind, rd, rs1, rs2, imm, w, ok);
    if (ok) begin
      sb.push_back('{addr: AW'(m_addr), data: w,
                     last: (last || (m_count + 1 == MAXW)), cyc: cyc + 1});
      m_addr  = (m_addr + 1) % (1 << AW);
      m_count = m_count + 1;
      if (last || m_count == MAXW) m_active = 0;
    end else begin
      m_err       = 1;
      m_err_index = m_count;
      m_active    = 0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic end_session();
    repeat (2) @(negedge clk);
    checkOutput("end_sb_drained", sb.size(), 0);
    checkOutput("end_ready", in_ready, 0);
    checkOutput("end_busy", busy, 0);
    checkOutput("end_err", err, m_err);
    checkOutput("end_count", words_written, m_count);
    if (m_err) checkOutput("end_err_index", err_index, m_err_index);
  endtask

  task automatic check_log(input int idx, input logic [AW-1:0] a, input logic [31:0] d);
    if (wr_log.size() <= idx) begin
      checkOutput("log_missing", wr_log.size(), idx + 1);
    end else begin
      checkOutput("log_addr", wr_log[idx].addr, a);
      checkOutput("log_data", wr_log[idx].data, d);
    end
  endtask

  int edge_kind [8] = '{4, 4, 15, 22, 23, 28, 28, 30};
  int edge_imm  [8] = '{2047, -2048, 31, 4094, -4096, 1048574, -1048576, 'hFFFFF000};
  int bad_kind  [8] = '{4, 2, 15, 17, 22, 22, 28, 31};
  int bad_imm   [8] = '{-2049, 2048, 32, -1, 4096, 3, 1048576, 'h800};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_wen", imem_wen, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", in_ready, 0);
    checkOutput("reset_count", words_written, 0);
    rst = 1'b0;

    // Program 1, with a start pulse during LOAD that must be ignored
    start_session(10'h010);
    applyStimulus(4, 1, 0, 0, 5, 0);
    start = 1'b1; base_addr = 10'h200;
    applyStimulus(3, 3, 1, 2, 0, 0);
    start = 1'b0;
    applyStimulus(2, 0, 1, 2, 8, 1);
    end_session();
    check_log(0, 10'h010, 32'h0050_0093);
    check_log(1, 10'h011, 32'h0020_81B3);
    check_log(2, 10'h012, 32'h0020_A423);

    start_session(10'h040);
    applyStimulus(22, 0, 1, 2, -4, 0);
    applyStimulus(17, 4, 1, 0, 3, 0);
    applyStimulus(30, 5, 0, 0, 'h12345000, 1);
    end_session();
    check_log(0, 10'h040, 32'hFE20_8EE3);
    check_log(1, 10'h041, 32'h4030_D213);
    check_log(2, 10'h042, 32'h1234_52B7);

    // Range error on record 2
    start_session(10'h080);
    applyStimulus(4, 1, 0, 0, 1, 0);
    applyStimulus(3, 2, 1, 1, 0, 0);
    applyStimulus(4, 3, 0, 0, 2048, 0);
    end_session();
    checkOutput("err_log_size", wr_log.size(), 2);

    // Address wrap
    start_session(10'h3FF);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    end_session();
    check_log(0, 10'h3FF, 32'h0000_0013);
    check_log(1, 10'h000, 32'h0000_0013);

    // Boundary immediates that must be accepted
    start_session(10'h100);
    for (int i = 0; i < 8; i++)
      applyStimulus(edge_kind[i], 7, 8, 9, edge_imm[i], i == 7);
    end_session();

    // Out-of-range immediates, each flagged last: ERR wins, no done
    foreach (bad_kind[i]) begin
      start_session(10'h120);
      applyStimulus(bad_kind[i], 1, 2, 3, bad_imm[i], 1);
      end_session();
    end

    // MAX_WORDS hit without in_last, then in_valid held in DONE
    start_session(10'h3F8);
    for (int i = 0; i < MAXW; i++) applyStimulus(3, i, i + 1, i + 2, 0, 0);
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("max_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    end_session();

    // MAX_WORDS hit together with in_last
    start_session(10'h200);
    for (int i = 0; i < MAXW; i++) applyStimulus(8, 1, 2, 3, 0, i == MAXW - 1);
    end_session();

    // Reset with a registered word in flight
    start_session(10'h300);
    applyStimulus(4, 1, 0, 0, 7, 0);
    applyStimulus(4, 2, 0, 0, 9, 0);
    rst = 1'b1;
    sb.delete();
    m_active = 0;
    @(negedge clk);
    checkOutput("rst_wen", imem_wen, 0);
    checkOutput("rst_addr", imem_addr, 0);
    checkOutput("rst_wdata", imem_wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", in_ready, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_index", err_index, 0);
    checkOutput("rst_count", words_written, 0);
    start = 1'b1; base_addr = 10'h005;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    checkOutput("rst_start_ignored", busy, 0);
    checkOutput("rst_log_size", wr_log.size(), 1);

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      int len;
      start_session(AW'($urandom_range(0, (1 << AW) - 1)));
      len = $urandom_range(1, 12);
      for (int r = 0; r < len && m_active; r++) begin
        int k;
        k = $urandom_range(0, 31);
        applyStimulus(k, $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), gen_imm(cls_tab[k]), r == len - 1);
      end
      end_session();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
